uart_rx_buffer: RTL and testbench

Receive-side byte buffer sitting directly downstream of the UART receiver and upstream of the APB register interface. Captures each received byte together with its parity-error flag on the receiver's one-cycle valid pulse and holds it in a first-word-fall-through FIFO until software pops it. Reports fill level, empty/full, a programmable threshold interrupt and a sticky overflow flag.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_fifo.sv | 75 +++++++
 rtl/uart_rx_buffer.sv | 76 +++++++
 tb/tb_uart_rx_buffer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and default sizing constants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int c_RX_DEPTH     = 16;
    localparam int c_RX_THRESHOLD = 8;

    typedef struct packed {
        logic       parity_error;
        logic [7:0] data;
    } uart_rx_entry_t;

    function automatic uart_rx_entry_t pack_rx_entry(input logic parity_error,
                                                     input logic [7:0] data);
        uart_rx_entry_t e;
        e.parity_error = parity_error;
        e.data         = data;
        return e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_fifo.sv
// ============================================================================
// Module      : uart_fifo
// Description : Parameterised first-word-fall-through FIFO with flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       arst_ni,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       push_drop_o
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_PW = c_AW + 1;

    logic [c_PW-1:0]  r_wptr;
    logic [c_PW-1:0]  r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [c_PW-1:0]  w_count;
    logic             w_empty;
    logic             w_full;
    logic             w_pop_eff;
    logic             w_push_eff;

    // Pointer MSB disambiguates full from empty; difference is the fill level.
    assign w_count    = r_wptr - r_rptr;
    assign w_empty    = (w_count == '0);
    assign w_full     = (w_count == c_PW'(DEPTH));
    assign w_pop_eff  = pop_i & ~w_empty & ~flush_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push_eff = push_i & ~flush_i & (~w_full | w_pop_eff);

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_eff) r_wptr <= r_wptr + 1'b1;
            if (w_pop_eff)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push_eff) begin
            r_mem[r_wptr[c_AW-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o   = r_mem[r_rptr[c_AW-1:0]];
    assign empty_o     = w_empty;
    assign full_o      = w_full;
    assign count_o     = w_count;
    assign push_drop_o = push_i & ~flush_i & ~w_push_eff;

endmodule

`default_nettype wire

// File: rtl/uart_rx_buffer.sv
// ============================================================================
// Module      : uart_rx_buffer
// Description : UART receive byte buffer with threshold and sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH     = c_RX_DEPTH,
    parameter int THRESHOLD = c_RX_THRESHOLD
) (
    input  logic                    clk_i,
    input  logic                    arst_ni,
    input  logic [7:0]              data_i,
    input  logic                    data_valid_i,
    input  logic                    parity_error_i,
    input  logic                    pop_i,
    input  logic                    flush_i,
    input  logic                    clear_overflow_i,
    output logic [7:0]              rd_data_o,
    output logic                    rd_parity_error_o,
    output logic                    empty_o,
    output logic                    full_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    threshold_o,
    output logic                    overflow_o
);

    localparam int c_CW = $clog2(DEPTH) + 1;
    localparam logic [c_CW-1:0] c_THRESHOLD = c_CW'(THRESHOLD);

    uart_rx_entry_t w_wr_entry;
    uart_rx_entry_t w_rd_entry;
    logic           w_push_drop;
    logic           r_overflow;

    assign w_wr_entry = pack_rx_entry(parity_error_i, data_i);

    uart_fifo #(
        .WIDTH ($bits(uart_rx_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .arst_ni     (arst_ni),
        .push_i      (data_valid_i),
        .wr_data_i   (w_wr_entry),
        .pop_i       (pop_i),
        .flush_i     (flush_i),
        .rd_data_o   (w_rd_entry),
        .empty_o     (empty_o),
        .full_o      (full_o),
        .count_o     (count_o),
        .push_drop_o (w_push_drop)
    );

    // A drop in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_overflow <= 1'b0;
        end else if (w_push_drop) begin
            r_overflow <= 1'b1;
        end else if (clear_overflow_i) begin
            r_overflow <= 1'b0;
        end
    end

    assign rd_data_o         = w_rd_entry.data;
    assign rd_parity_error_o = w_rd_entry.parity_error;
    assign threshold_o       = (count_o >= c_THRESHOLD);
    assign overflow_o        = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_buffer.sv
// ============================================================================
// Module      : tb_uart_rx_buffer
// Description : Self-checking bench for uart_rx_buffer against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_buffer;

    localparam int c_DEPTH = 16;
    localparam int c_THR   = 8;

    logic       clk_i = 1'b0;
    logic       arst_ni = 1'b0;
    logic [7:0] data_i = '0;
    logic       data_valid_i = 1'b0;
    logic       parity_error_i = 1'b0;
    logic       pop_i = 1'b0;
    logic       flush_i = 1'b0;
    logic       clear_overflow_i = 1'b0;
    logic [7:0] rd_data_o;
    logic       rd_parity_error_o;
    logic       empty_o;
    logic       full_o;
    logic [4:0] count_o;
    logic       threshold_o;
    logic       overflow_o;

    int n_total = 0;
    int n_pass  = 0;

    logic [8:0] model_q[$];
    logic       model_ov = 1'b0;

    uart_rx_buffer dut (
        .clk_i             (clk_i),
        .arst_ni           (arst_ni),
        .data_i            (data_i),
        .data_valid_i      (data_valid_i),
        .parity_error_i    (parity_error_i),
        .pop_i             (pop_i),
        .flush_i           (flush_i),
        .clear_overflow_i  (clear_overflow_i),
        .rd_data_o         (rd_data_o),
        .rd_parity_error_o (rd_parity_error_o),
        .empty_o           (empty_o),
        .full_o            (full_o),
        .count_o           (count_o),
        .threshold_o       (threshold_o),
        .overflow_o        (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Compare every observable output against the queue model.
    task automatic verify(input string tag);
        chk({tag, ".count"},     32'(count_o),     32'(model_q.size()));
        chk({tag, ".empty"},     32'(empty_o),     32'(model_q.size() == 0));
        chk({tag, ".full"},      32'(full_o),      32'(model_q.size() == c_DEPTH));
        chk({tag, ".threshold"}, 32'(threshold_o), 32'(model_q.size() >= c_THR));
        chk({tag, ".overflow"},  32'(overflow_o),  32'(model_ov));
        if (model_q.size() != 0)
            chk({tag, ".head"}, 32'({rd_parity_error_o, rd_data_o}), 32'(model_q[0]));
    endtask

    // One clock with the given strobes; model updated from pre-edge state.
    task automatic step(input logic dv, input logic [7:0] d, input logic pe,
                        input logic pop, input logic fl, input logic clr);
        logic pop_eff;
        logic drop;
        data_valid_i     = dv;
        data_i           = d;
        parity_error_i   = pe;
        pop_i            = pop;
        flush_i          = fl;
        clear_overflow_i = clr;
        @(posedge clk_i);
        drop = 1'b0;
        if (fl) begin
            model_q.delete();
        end else begin
            pop_eff = pop && (model_q.size() != 0);
            if (pop_eff) void'(model_q.pop_front());
            if (dv) begin
                if (model_q.size() < c_DEPTH) model_q.push_back({pe, d});
                else drop = 1'b1;
            end
        end
        if (drop) model_ov = 1'b1;
        else if (clr) model_ov = 1'b0;
        #1;
        data_valid_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0; clear_overflow_i = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic pe);
        step(1'b1, d, pe, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop_one();
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst.empty", 32'(empty_o), 32'd1);
        chk("rst.count", 32'(count_o), 32'd0);
        chk("rst.overflow", 32'(overflow_o), 32'd0);
        chk("rst.rd_data", 32'(rd_data_o), 32'h00);
        chk("rst.rd_pe", 32'(rd_parity_error_o), 32'd0);
        chk("rst.full", 32'(full_o), 32'd0);
        @(negedge clk_i); arst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Two entries with differing parity flags
        push(8'hA5, 1'b0); verify("p1");
        chk("p1.data", 32'(rd_data_o), 32'hA5);
        push(8'h3C, 1'b1); verify("p2");
        chk("p2.count", 32'(count_o), 32'd2);
        pop_one(); verify("pop1");
        chk("pop1.data", 32'(rd_data_o), 32'h3C);
        chk("pop1.pe", 32'(rd_parity_error_o), 32'd1);
        pop_one(); verify("pop2");
        chk("pop2.empty", 32'(empty_o), 32'd1);

        // Fill to full, watch threshold, then overflow
        for (int i = 0; i < c_DEPTH; i++) begin
            push(8'(i), 1'b0); verify("fill");
        end
        chk("fill.full", 32'(full_o), 32'd1);
        push(8'hFF, 1'b1); verify("ovf");
        chk("ovf.flag", 32'(overflow_o), 32'd1);
        for (int i = 0; i < c_DEPTH; i++) begin
            chk("drain.data", 32'(rd_data_o), 32'(i));
            pop_one(); verify("drain");
        end

        // Full with simultaneous push and pop
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1); verify("clr0");
        for (int i = 0; i < c_DEPTH; i++) begin
            push(8'($urandom), 1'($urandom)); verify("refill");
        end
        step(1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0); verify("pushpop_full");
        chk("pushpop_full.ovf", 32'(overflow_o), 32'd0);
        for (int i = 0; i < c_DEPTH; i++) begin
            if (i == c_DEPTH - 1) chk("last.data", 32'(rd_data_o), 32'h55);
            pop_one(); verify("drain2");
        end

        // Pop on empty, then flush with a same-cycle push
        pop_one(); verify("pop_empty");
        for (int i = 0; i < 5; i++) begin
            push(8'($urandom), 1'($urandom)); verify("pre_flush");
        end
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0); verify("flush");
        chk("flush.count", 32'(count_o), 32'd0);

        // Overflow coincident with clear: set wins
        for (int i = 0; i < c_DEPTH; i++) begin
            push(8'($urandom), 1'($urandom)); verify("fill3");
        end
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b1); verify("ovf_clr");
        chk("ovf_clr.flag", 32'(overflow_o), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1); verify("clr");
        chk("clr.flag", 32'(overflow_o), 32'd0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0); verify("flush2");

        // Randomised traffic: push-heavy then pop-heavy phases
        for (int i = 0; i < 400; i++) begin
            int pp;
            pp = (i < 200) ? 75 : 30;
            step(1'($urandom_range(0, 99) < pp), 8'($urandom), 1'($urandom),
                 1'($urandom_range(0, 99) < (100 - pp)),
                 1'($urandom_range(0, 99) < 2), 1'($urandom_range(0, 99) < 5));
            verify("rand");
        end

        // Asynchronous reset mid-stream
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            push(8'($urandom), 1'($urandom)); verify("pre_rst");
        end
        arst_ni = 1'b0;
        #2;
        chk("arst.count", 32'(count_o), 32'd0);
        chk("arst.empty", 32'(empty_o), 32'd1);
        chk("arst.rd_data", 32'(rd_data_o), 32'h00);
        chk("arst.overflow", 32'(overflow_o), 32'd0);
        model_q.delete();
        model_ov = 1'b0;
        @(negedge clk_i); arst_ni = 1'b1;
        @(posedge clk_i); #1;
        verify("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
